// File: rtl/wb_burst_master.sv
// Wishbone B3 master: one command becomes a single incrementing burst (cti 010/111).
// Optional per-beat ack timeout compiled in with `define WB_BURST_TIMEOUT_EN.
module wb_burst_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int lw      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [lw-1:0] cmd_len_i,
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a command transfers on a cycle with cmd_valid_i & cmd_ready_o;
  // a write beat transfers on a cycle with wr_valid_i & wr_ready_o; rd_valid_o
  // is a one-cycle strobe with no backpressure.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [lw:0] LEN_ONE = (lw+1)'(1);
  localparam logic [lw:0] LEN_MAX = {1'b1, {lw{1'b0}}};

  state_t        state_q, state_d;
  logic [aw-1:0] adr_q;
  logic          we_q;
  logic [lw:0]   rem_q;
  logic          err_q;
  logic [dw-1:0] rd_dat_q;
  logic          rd_valid_q;

  logic in_burst;
  logic accept;
  logic stb;
  logic last_beat;
  logic beat_ok;
  logic abort;
  logic to_hit;
  logic unused_adr_bits;

  assign in_burst  = (state_q == BURST);
  assign accept    = (state_q == IDLE) & cmd_valid_i;
  // A write with no stream data stalls by dropping stb while cyc stays high.
  assign stb       = in_burst & (~we_q | wr_valid_i);
  assign last_beat = (rem_q == LEN_ONE);
  assign beat_ok   = stb & wb_ack_i & ~wb_err_i;
  assign abort     = stb & (wb_err_i | to_hit);

  assign unused_adr_bits = ^cmd_adr_i[1:0];

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  // Only cycles with stb high and no response count toward the limit.
  assign to_hit = stb & ~wb_ack_i & ~wb_err_i & (to_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt_q <= '0;
    end else if (!in_burst || (stb && wb_ack_i)) begin
      to_cnt_q <= '0;
    end else if (stb && !wb_err_i) begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = BURST;
      BURST:   if (abort || (beat_ok && last_beat)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr_q      <= '0;
      we_q       <= 1'b0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= beat_ok & ~we_q;
      if (beat_ok && !we_q) rd_dat_q <= wb_dat_i;
      if (accept) begin
        adr_q <= {cmd_adr_i[aw-1:2], 2'b00};
        we_q  <= cmd_we_i;
        rem_q <= (cmd_len_i == '0) ? LEN_MAX : {1'b0, cmd_len_i};
        err_q <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end else if (beat_ok) begin
        adr_q <= adr_q + aw'(4);
        rem_q <= rem_q - LEN_ONE;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = beat_ok & we_q;
  assign rd_dat_o    = rd_dat_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign wb_adr_o    = in_burst ? adr_q : '0;
  assign wb_dat_o    = (in_burst && we_q) ? wr_dat_i : '0;
  assign wb_sel_o    = in_burst ? 4'hF : 4'h0;
  assign wb_we_o     = in_burst & we_q;
  assign wb_bte_o    = 2'b00;
  assign wb_cti_o    = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
  assign wb_cyc_o    = in_burst;
  assign wb_stb_o    = stb;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a registered-ack burst slave model.
// Define WB_BURST_TIMEOUT_EN to build and exercise the ack-timeout variant (TIMEOUT=8).
module tb_wb_burst_master;

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wr_dat_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] rd_dat_o;
  logic        rd_valid_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  dbg_state_o;

  wb_burst_master #(.dw(32), .aw(32), .lw(8), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wr_dat_i(wr_dat_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave model: ack registered one cycle after stb, then every cycle of the burst
  logic        ack_r;
  logic        ack_en;
  int          err_at;
  int          sb_beats;
  logic        err_now;
  logic [31:0] mem [0:1023];

  assign err_now  = ack_r & wb_cyc_o & wb_stb_o & (sb_beats == err_at);
  assign wb_ack_i = ack_r & wb_cyc_o & wb_stb_o & ~err_now;
  assign wb_err_i = err_now;
  assign wb_dat_i = mem[wb_adr_o[11:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r    <= 1'b0;
      sb_beats <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC000_0000 | i;
    end else begin
      ack_r <= ack_en & wb_cyc_o & wb_stb_o & ~(ack_r & (wb_cti_o == 3'b111));
      if (!wb_cyc_o) sb_beats <= 0;
      else if (wb_ack_i) sb_beats <= sb_beats + 1;
      if (wb_ack_i && wb_we_o) mem[wb_adr_o[11:2]] <= wb_dat_o;
    end
  end

  // Write-stream driver and bus monitor
  logic [31:0] wr_src[$];
  logic [31:0] adr_log[$];
  logic [31:0] cti_log[$];
  logic [31:0] wdat_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] stall_adr;
  int          stall_beat = -1;
  int          stall_left = 0;
  int          wr_pops = 0;
  int          wr_rdy_n = 0;
  int          stall_n = 0;
  int          stall_bad = 0;
  int          done_n = 0;
  logic        pop_pend = 1'b0;

  always @(negedge clk) begin
    if (pop_pend && wr_src.size() > 0) begin
      void'(wr_src.pop_front());
      wr_pops++;
    end
    pop_pend = 1'b0;
    if (stall_beat == wr_pops && stall_left > 0) begin
      wr_valid_i = 1'b0;
      stall_left--;
    end else begin
      wr_valid_i = (wr_src.size() > 0);
      wr_dat_i   = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
    end
    #1;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      adr_log.push_back(wb_adr_o);
      cti_log.push_back({29'd0, wb_cti_o});
      if (wb_we_o) wdat_log.push_back(wb_dat_o);
    end
    if (wb_cyc_o && !wb_stb_o) begin
      stall_n++;
      if (wb_adr_o !== stall_adr || wb_cti_o !== 3'b010) stall_bad++;
    end
    if (rd_valid_o) rd_log.push_back(rd_dat_o);
    if (wr_ready_o) wr_rdy_n++;
    if (done_o) done_n++;
    pop_pend = wr_ready_o;
  end

  // Command driver: issue one command, wait (bounded) for done_o
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len,
                         input int budget, output int lat, output logic err_d,
                         output logic rdy_d);
    int t0;
    adr_log.delete(); cti_log.delete(); wdat_log.delete(); rd_log.delete();
    wr_rdy_n = 0; stall_n = 0; stall_bad = 0; done_n = 0;
    lat = -1; err_d = 1'bx; rdy_d = 1'bx;
    @(negedge clk);
    cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_valid_i = 1'b1;
    t0 = cyc_n;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = 32'hDEAD_BEE0; cmd_len_i = 8'h55;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        lat = cyc_n - t0; err_d = err_o; rdy_d = cmd_ready_o;
        break;
      end
      @(negedge clk);
    end
    #2;
  endtask

  int   lat;
  logic e_d;
  logic r_d;
  int   bad;

  initial begin
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    wr_dat_i = '0; wr_valid_i = 1'b0; ack_en = 1'b1; err_at = -1; stall_adr = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 1);
    check("rst_cyc",       {31'd0, wb_cyc_o}, 0);
    check("rst_stb",       {31'd0, wb_stb_o}, 0);
    check("rst_done",      {31'd0, done_o}, 0);
    check("rst_err",       {31'd0, err_o}, 0);
    check("rst_rd_valid",  {31'd0, rd_valid_o}, 0);
    check("rst_adr",       wb_adr_o, 0);
    check("rst_state",     {30'd0, dbg_state_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;

    // Write burst 0x10 x4, data always valid
    wr_src = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; wr_pops = 0;
    run_cmd(1'b1, 32'h10, 8'd4, 50, lat, e_d, r_d);
    check("wr4_latency", lat, 6);
    check("wr4_beats", adr_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr4_adr%0d", k), adr_log[k], 32'h10 + 4*k);
      check($sformatf("wr4_cti%0d", k), cti_log[k], (k == 3) ? 32'd7 : 32'd2);
      check($sformatf("wr4_dat%0d", k), wdat_log[k], 32'hA0 + k);
    end
    check("wr4_ready_pulses", wr_rdy_n, 4);
    check("wr4_err", {31'd0, e_d}, 0);
    check("wr4_cmd_ready_in_done", {31'd0, r_d}, 0);
    check("wr4_cyc_in_done", {31'd0, wb_cyc_o}, 0);

    // Read burst 0x40 x3
    exp_q = '{32'hC000_0010, 32'hC000_0011, 32'hC000_0012};
    run_cmd(1'b0, 32'h40, 8'd3, 50, lat, e_d, r_d);
    check("rd3_latency", lat, 5);
    check("rd3_pulses", rd_log.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("rd3_dat%0d", k), rd_log[k], exp_q[k]);
    check("rd3_cti_last", cti_log[2], 7);
    check("rd3_err", {31'd0, e_d}, 0);

    // Single-beat write, low address bits forced to zero
    wr_src = '{32'hD5}; wr_pops = 0;
    run_cmd(1'b1, 32'h23, 8'd1, 50, lat, e_d, r_d);
    check("wr1_latency", lat, 3);
    check("wr1_beats", adr_log.size(), 1);
    check("wr1_adr", adr_log[0], 32'h20);
    check("wr1_cti", cti_log[0], 7);
    check("wr1_dat", wdat_log[0], 32'hD5);

    // cmd_len=0 means 256 beats
    run_cmd(1'b0, 32'h400, 8'd0, 400, lat, e_d, r_d);
    check("rd256_latency", lat, 258);
    check("rd256_pulses", rd_log.size(), 256);
    bad = 0;
    for (int k = 0; k < 256; k++) if (rd_log[k] !== (32'hC000_0100 + k)) bad++;
    check("rd256_data_mismatches", bad, 0);
    check("rd256_cti_penult", cti_log[254], 2);
    check("rd256_cti_last", cti_log[255], 7);

    // Address wraps modulo 2^32
    run_cmd(1'b0, 32'hFFFF_FFFC, 8'd2, 50, lat, e_d, r_d);
    check("wrap_adr0", adr_log[0], 32'hFFFF_FFFC);
    check("wrap_adr1", adr_log[1], 32'h0000_0000);
    check("wrap_dat0", rd_log[0], 32'hC000_03FF);
    check("wrap_dat1", rd_log[1], 32'hC000_0000);
    check("wrap_err", {31'd0, e_d}, 0);

    // Write stall: no stream data for 3 cycles before beat 2
    wr_src = '{32'hE0, 32'hE1, 32'hE2, 32'hE3}; wr_pops = 0;
    stall_beat = 1; stall_left = 3; stall_adr = 32'h84;
    run_cmd(1'b1, 32'h80, 8'd4, 60, lat, e_d, r_d);
    stall_beat = -1;
    check("stall_cycles", stall_n, 3);
    check("stall_adr_cti_moved", stall_bad, 0);
    check("stall_beats", wdat_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_dat%0d", k), wdat_log[k], 32'hE0 + k);
      check($sformatf("stall_adr%0d", k), adr_log[k], 32'h80 + 4*k);
    end

    // Bus error on beat 2 of 5
    err_at = 1;
    run_cmd(1'b0, 32'h40, 8'd5, 50, lat, e_d, r_d);
    err_at = -1;
    check("err_latency", lat, 4);
    check("err_flag", {31'd0, e_d}, 1);
    check("err_rd_pulses", rd_log.size(), 1);
    check("err_rd_dat0", rd_log[0], 32'hC000_0010);
    check("err_cyc_in_done", {31'd0, wb_cyc_o}, 0);
    @(negedge clk); #2;
    check("err_held_idle", {31'd0, err_o}, 1);
    wr_src = '{32'h77}; wr_pops = 0;
    run_cmd(1'b1, 32'h200, 8'd1, 50, lat, e_d, r_d);
    check("err_cleared", {31'd0, e_d}, 0);
    check("err_next_dat", wdat_log[0], 32'h77);

    // Asynchronous reset in the middle of a read burst
    done_n = 0;
    @(negedge clk);
    cmd_we_i = 1'b0; cmd_adr_i = 32'h100; cmd_len_i = 8'd20; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("mid_cyc_before", {31'd0, wb_cyc_o}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", {31'd0, wb_cyc_o}, 0);
    check("mid_rst_stb", {31'd0, wb_stb_o}, 0);
    check("mid_rst_adr", wb_adr_o, 0);
    check("mid_rst_cti", {29'd0, wb_cti_o}, 0);
    check("mid_rst_sel", {28'd0, wb_sel_o}, 0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 1);
    check("mid_rst_rd_valid", {31'd0, rd_valid_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("mid_rst_no_done", done_n, 0);

`ifdef WB_BURST_TIMEOUT_EN
    // Slave never acks: abort after TIMEOUT stalled cycles
    ack_en = 1'b0;
    run_cmd(1'b0, 32'h40, 8'd2, 40, lat, e_d, r_d);
    ack_en = 1'b1;
    check("to_latency", lat, 9);
    check("to_err", {31'd0, e_d}, 1);
    check("to_rd_pulses", rd_log.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone B3 master that turns one command (direction, start address, beat count) into a single incrementing-burst cycle on the shared bus.
Sits directly upstream of wb_ram and drives its wb_* slave inputs.
Write data is pulled from a valid/ready stream. Read data is pushed out as a valid-qualified stream with no backpressure.
Used by loaders and DMA-style clients that fill or drain on-chip RAM.

Parameters:
dw, 32, data width; must be 32 because wb_sel_o is 4 bits.
aw, 32, byte address width.
lw, 8, command length width; beat count 1..2^lw, where cmd_len=0 encodes 2^lw.
TIMEOUT, 1024, max cycles waiting for ack/err per beat; used only with WB_BURST_TIMEOUT_EN.

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write burst, 0=read burst
cmd_adr_i  in  aw  start byte address; bits[1:0] ignored (forced 0)
cmd_len_i  in  lw  beat count
wr_dat_i  in  dw  write stream data
wr_valid_i  in  1  write data available
wr_ready_o  out  1  write beat consumed this cycle
rd_dat_o  out  dw  read stream data
rd_valid_o  out  1  one-cycle strobe per read beat
done_o  out  1  one-cycle pulse at burst end
err_o  out  1  status of last burst; valid with done_o, held until next command accepted
wb_adr_o  out  aw  bus address
wb_dat_o  out  dw  bus write data
wb_sel_o  out  4  always 4'hF during a cycle
wb_we_o  out  1  bus write enable
wb_bte_o  out  2  always 2'b00 (linear)
wb_cti_o  out  3  cycle type
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_dat_i  in  dw  bus read data
wb_ack_i  in  1  bus ack
wb_err_i  in  1  bus error

Behaviour:
- Reset (async, wb_rst_n_i=0): state IDLE. All outputs 0 except cmd_ready_o=1. Internal address/counters 0.
- States: IDLE, BURST, DONE.
- IDLE:
  - cmd_ready_o=1; cyc/stb=0.
  - On cmd_valid_i, latch adr, we, len (0 -> 2^lw), clear err_o, go BURST next cycle.
- BURST:
  - wb_cyc_o=1 for the whole burst, including write stalls.
  - wb_stb_o=1 except on writes while wr_valid_i=0; stb drops until data arrives, with adr/cti held.
  - wb_dat_o=wr_dat_i (combinational pass of stream head).
  - wr_ready_o=wb_ack_i & wb_stb_o & wb_we_o.
  - wb_cti_o=3'b010 while remaining beats>1; 3'b111 on the final beat, including single-beat commands.
- Beat completion: wb_ack_i & wb_stb_o.
  - Address += 4, wrapping modulo 2^aw with no error.
  - Remaining count -= 1.
  - For reads: rd_dat_o<=wb_dat_i and rd_valid_o=1 the next cycle (registered, 1-cycle latency).
- Final beat acked: drop cyc/stb the next cycle and enter DONE.
- wb_err_i & wb_stb_o (priority over ack in the same cycle):
  - Abort burst, set err_o=1, enter DONE.
  - No rd_valid_o or wr_ready_o for that beat.
  - Remaining write data is left in the stream; the client must flush it.
- DONE: done_o=1 for exactly one cycle, cmd_ready_o=0, then IDLE.
- Acks arriving in IDLE/DONE are ignored.
- The earliest new command is accepted in the cycle after DONE.
- Throughput: with zero-wait slave (wb_ram pipelined ack), N beats take N+2 cycles from accept to done_o.
- Reset mid-burst: outputs drop immediately (async); no done_o is produced.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
WB_BURST_TIMEOUT_EN:
- Compiled in: a per-beat counter, cleared on each ack, counts cycles with stb=1 and no ack/err.
- Reaching TIMEOUT aborts exactly as wb_err_i does (err_o=1, DONE).
- Write stalls (stb=0) do not count.
- Compiled out: no counter; the master waits indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Write burst: cmd_we=1, adr=0x10, len=4, data A0..A3 always valid, zero-wait slave -> adr 0x10,0x14,0x18,0x1C; cti 010,010,010,111; 4 wr_ready pulses; done_o 6 cycles after accept; err_o=0.
- Read burst: cmd_we=0, adr=0x40, len=3, slave returns B0..B2 -> rd_valid_o 3 pulses with B0,B1,B2 in order; cyc deasserts after 3rd ack.
- Single beat: len=1 -> one stb with cti=111; done_o pulses; cmd_len=0 with lw=8 -> exactly 256 beats.
- Write stall: wr_valid_i low for 3 cycles before beat 2 -> stb=0 while cyc=1, adr/cti held for 3 cycles, burst completes with correct data order.
- Error: wb_err_i on beat 2 of len=5 -> cyc drops next cycle, done_o with err_o=1, only 1 beat counted; next command clears err_o.
- Reset mid-burst (and, with WB_BURST_TIMEOUT_EN, TIMEOUT=8 with a slave that never acks): reset -> all bus outputs 0 at once, cmd_ready_o=1. Timeout -> done_o with err_o=1 after 8 stalled cycles.
